// File: rtl/keypad_pkg.sv
// Shared constants, function-key map and debounce state encoding for the keypad front end.
package keypad_pkg;

   // Matrix geometry and key-code field widths (code = row*8 + col)
   localparam int unsigned NUM_ROWS   = 4;
   localparam int unsigned NUM_COLS   = 8;
   localparam int unsigned ROW_W      = 2;
   localparam int unsigned COL_W      = 3;
   localparam int unsigned CODE_W     = ROW_W + COL_W;
   localparam int unsigned NUM_KEYS   = NUM_ROWS * NUM_COLS;

   // Columns 0..3 are hex digits, columns 4..7 are function keys
   localparam int unsigned HEX_COLS   = 4;

   localparam int unsigned ENTRY_W    = 16;
   localparam int unsigned MAX_DIGITS = 4;
   localparam int unsigned NUM_FN     = 16;

   // Function-key pulse indices; 12..14 are reserved but still pulse
   localparam int unsigned FN_STEP     = 0;
   localparam int unsigned FN_RUNHALT  = 1;
   localparam int unsigned FN_RESET    = 2;
   localparam int unsigned FN_LOAD     = 3;
   localparam int unsigned FN_STOREINC = 4;
   localparam int unsigned FN_DEC      = 5;
   localparam int unsigned FN_IRQ      = 6;
   localparam int unsigned FN_TOA      = 7;
   localparam int unsigned FN_TOX      = 8;
   localparam int unsigned FN_TOY      = 9;
   localparam int unsigned FN_TOSP     = 10;
   localparam int unsigned FN_TOPC     = 11;
   localparam int unsigned FN_CLEAR    = 15;

   typedef enum logic [1:0] {
      StReleased,
      StPressCand,
      StHeld,
      StRelCand
   } deb_state_e;

   function automatic logic is_hex_key(input logic [CODE_W-1:0] code);
      return code[COL_W-1:0] < COL_W'(HEX_COLS);
   endfunction

   // row*4 + (col mod 4): the hex nibble for digit keys, the pulse index for function keys
   function automatic logic [3:0] key_index(input logic [CODE_W-1:0] code);
      return {code[CODE_W-1:COL_W], code[1:0]};
   endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Entry-register / command-strobe bundle between the keypad and the CPU control block.
interface keypad_entry_if;
   import keypad_pkg::*;

   logic [ENTRY_W-1:0] user_input;
   logic               input_valid;
   logic [2:0]         digit_count;
   logic [NUM_FN-1:0]  fn_pulse;
   logic [CODE_W-1:0]  key_code;

   modport master (
      output user_input,
      output input_valid,
      output digit_count,
      output fn_pulse,
      output key_code
   );

   modport slave (
      input user_input,
      input input_valid,
      input digit_count,
      input fn_pulse,
      input key_code
   );

endinterface

// File: rtl/matrix_scan.sv
// Column scanner: drives one column low at a time, synchronises rows, builds a 32-bit frame
// snapshot and classifies each completed frame as empty, single key or multiple keys.
module matrix_scan
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 5000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_ROWS-1:0] rows_n,
   output logic [NUM_COLS-1:0] cols_n,
   output logic                frame_done,
   output logic                frame_empty,
   output logic                frame_multi,
   output logic [CODE_W-1:0]   frame_code
);

   localparam int unsigned DWELL_W = $clog2(SCAN_DIV);

   logic [DWELL_W-1:0]  dwell_q, dwell_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [NUM_ROWS-1:0] sync1_q, sync2_q;
   logic [NUM_KEYS-1:0] snap_q, snap_d;
   logic                done_q, done_d;
   logic                last_dwell;
   logic [5:0]          pop;
   logic [CODE_W-1:0]   code;

   assign last_dwell = (dwell_q == DWELL_W'(SCAN_DIV - 1));
   assign cols_n     = ~(NUM_COLS'(1) << col_q);

   // Dwell counter, column advance and per-column snapshot capture
   always_comb begin
      dwell_d = dwell_q + 1'b1;
      col_d   = col_q;
      snap_d  = snap_q;
      done_d  = 1'b0;
      if (last_dwell) begin
         dwell_d = '0;
         col_d   = col_q + 1'b1;
         for (int r = 0; r < NUM_ROWS; r++) begin
            snap_d[r * NUM_COLS + int'(col_q)] = ~sync2_q[r];
         end
         done_d = (col_q == COL_W'(NUM_COLS - 1));
      end
   end

   // Scan state, two-flop row synchroniser and snapshot registers
   always_ff @(posedge clk) begin
      if (rst) begin
         dwell_q <= '0;
         col_q   <= '0;
         sync1_q <= '1;
         sync2_q <= '1;
         snap_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         dwell_q <= dwell_d;
         col_q   <= col_d;
         sync1_q <= rows_n;
         sync2_q <= sync1_q;
         snap_q  <= snap_d;
         done_q  <= done_d;
      end
   end

   // Frame classification: bit index in the snapshot is already the key code
   always_comb begin
      pop  = '0;
      code = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (snap_q[i]) begin
            pop  = pop + 1'b1;
            code = CODE_W'(i);
         end
      end
   end

   assign frame_done  = done_q;
   assign frame_empty = (pop == 6'd0);
   assign frame_multi = (pop > 6'd1);
   assign frame_code  = code;

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: matrix scan, frame-level debounce and the hex entry register with
// one-cycle function-key strobes for the CPU control block.
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 5000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_ROWS-1:0] rows_n,
   output logic [NUM_COLS-1:0] cols_n,
   keypad_entry_if.master      entry
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

   logic              frame_done, frame_empty, frame_multi;
   logic [CODE_W-1:0] frame_code;
   logic              frame_key, frame_none;

   deb_state_e        state_q, state_d;
   logic [CODE_W-1:0] cand_q, cand_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              accept;

   logic [ENTRY_W-1:0] user_input_q, user_input_d;
   logic               input_valid_q, input_valid_d;
   logic [2:0]         digit_count_q, digit_count_d;
   logic [NUM_FN-1:0]  fn_pulse_q, fn_pulse_d;
   logic [CODE_W-1:0]  key_code_q, key_code_d;
   logic               clear_pending_q, clear_pending_d;

   matrix_scan #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk         (clk),
      .rst         (rst),
      .rows_n      (rows_n),
      .cols_n      (cols_n),
      .frame_done  (frame_done),
      .frame_empty (frame_empty),
      .frame_multi (frame_multi),
      .frame_code  (frame_code)
   );

   // Multi-key frames qualify as neither, so they leave the FSM untouched
   assign frame_key  = frame_done & ~frame_empty & ~frame_multi;
   assign frame_none = frame_done & frame_empty;

   // Debounce FSM next state; accept fires on the frame where the count is reached
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      cnt_inc = cnt_q + 1'b1;
      accept  = 1'b0;
      unique case (state_q)
         StReleased: begin
            if (frame_key) begin
               cand_d = frame_code;
               cnt_d  = CNT_W'(1);
               if (CNT_DONE == CNT_W'(1)) begin
                  accept  = 1'b1;
                  state_d = StHeld;
               end else begin
                  state_d = StPressCand;
               end
            end
         end
         StPressCand: begin
            if (frame_key) begin
               if (frame_code == cand_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_DONE) begin
                     accept  = 1'b1;
                     state_d = StHeld;
                  end
               end else begin
                  cand_d = frame_code;
                  cnt_d  = CNT_W'(1);
               end
            end else if (frame_none) begin
               state_d = StReleased;
            end
         end
         StHeld: begin
            if (frame_none) begin
               cnt_d   = CNT_W'(1);
               state_d = (CNT_DONE == CNT_W'(1)) ? StReleased : StRelCand;
            end
         end
         StRelCand: begin
            if (frame_key) begin
               state_d = StHeld;
            end else if (frame_none) begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_DONE) begin
                  state_d = StReleased;
               end
            end
         end
         default: state_d = StReleased;
      endcase
   end

   // Debounce state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StReleased;
         cand_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
      end
   end

   // Entry register next state: digit shift, clear key, or pulse followed by deferred clear
   always_comb begin
      user_input_d    = user_input_q;
      input_valid_d   = input_valid_q;
      digit_count_d   = digit_count_q;
      key_code_d      = key_code_q;
      fn_pulse_d      = '0;
      clear_pending_d = 1'b0;
      if (clear_pending_q) begin
         user_input_d  = '0;
         input_valid_d = 1'b0;
         digit_count_d = '0;
      end
      if (accept) begin
         key_code_d = cand_d;
         if (is_hex_key(cand_d)) begin
            user_input_d  = {user_input_q[ENTRY_W-5:0], key_index(cand_d)};
            input_valid_d = 1'b1;
            if (digit_count_q < 3'(MAX_DIGITS)) begin
               digit_count_d = digit_count_q + 3'd1;
            end
         end else if (key_index(cand_d) == 4'(FN_CLEAR)) begin
            user_input_d  = '0;
            input_valid_d = 1'b0;
            digit_count_d = '0;
         end else begin
            // Entry stays visible during the strobe so the CPU can latch it
            fn_pulse_d      = NUM_FN'(1) << key_index(cand_d);
            clear_pending_d = 1'b1;
         end
      end
   end

   // Entry register and strobe outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         user_input_q    <= '0;
         input_valid_q   <= 1'b0;
         digit_count_q   <= '0;
         key_code_q      <= '0;
         fn_pulse_q      <= '0;
         clear_pending_q <= 1'b0;
      end else begin
         user_input_q    <= user_input_d;
         input_valid_q   <= input_valid_d;
         digit_count_q   <= digit_count_d;
         key_code_q      <= key_code_d;
         fn_pulse_q      <= fn_pulse_d;
         clear_pending_q <= clear_pending_d;
      end
   end

   assign entry.user_input  = user_input_q;
   assign entry.input_valid = input_valid_q;
   assign entry.digit_count = digit_count_q;
   assign entry.fn_pulse    = fn_pulse_q;
   assign entry.key_code    = key_code_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: models the key matrix, steps through whole scan frames
// and checks the entry outputs against hand-computed values.
module tb_keypad_entry;
   import keypad_pkg::*;

   localparam int unsigned SCAN_DIV       = 4;
   localparam int unsigned DEBOUNCE_SCANS = 4;
   localparam int unsigned FRAME          = SCAN_DIV * 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  rows_n;
   logic [7:0]  cols_n;
   logic [31:0] keys;

   int checks = 0;
   int errors = 0;

   keypad_entry_if entry ();

   keypad_entry #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .rows_n (rows_n),
      .cols_n (cols_n),
      .entry  (entry)
   );

   always #5 clk = ~clk;

   // Key matrix: a pressed key pulls its row low while its column is driven low
   always_comb begin
      rows_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 8; c++) begin
            if (!cols_n[c] && keys[r * 8 + c]) rows_n[r] = 1'b0;
         end
      end
   end

   // Strobe monitor: pulse width, which pulse, entry during and after the pulse
   int          pulse_cycles  = 0;
   logic [15:0] pulse_seen    = '0;
   logic [15:0] ui_at_pulse   = '0;
   logic        vld_at_pulse  = 1'b0;
   logic [15:0] ui_after      = 16'hFFFF;
   logic        vld_after     = 1'b1;
   logic [2:0]  cnt_after     = 3'h7;
   logic        after_pending = 1'b0;

   always @(negedge clk) begin
      if (entry.fn_pulse != '0) begin
         pulse_cycles <= pulse_cycles + 1;
         pulse_seen   <= pulse_seen | entry.fn_pulse;
         ui_at_pulse  <= entry.user_input;
         vld_at_pulse <= entry.input_valid;
      end
      if (after_pending) begin
         ui_after  <= entry.user_input;
         vld_after <= entry.input_valid;
         cnt_after <= entry.digit_count;
      end
      after_pending <= (entry.fn_pulse != '0);
   end

   function automatic logic [31:0] hex_key(input int n);
      return 32'd1 << ((n / 4) * 8 + (n % 4));
   endfunction

   function automatic logic [31:0] fn_key(input int i);
      return 32'd1 << ((i / 4) * 8 + 4 + (i % 4));
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n);
      cyc(n * FRAME);
   endtask

   task automatic tap(input logic [31:0] mask, input int on, input int off);
      keys = mask;
      frames(on);
      keys = '0;
      frames(off);
   endtask

   task automatic check_entry(input string tag, input logic [15:0] ui, input logic vld,
                              input logic [2:0] cnt, input logic [4:0] code);
      check({tag, "_ui"}, 32'(entry.user_input), 32'(ui));
      check({tag, "_valid"}, 32'(entry.input_valid), 32'(vld));
      check({tag, "_count"}, 32'(entry.digit_count), 32'(cnt));
      check({tag, "_code"}, 32'(entry.key_code), 32'(code));
   endtask

   initial begin
      rst  = 1'b1;
      keys = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state, then column 1 after one dwell period
      check("rst_cols", 32'(cols_n), 32'h0000_00FE);
      check("rst_pulse", 32'(entry.fn_pulse), 32'h0);
      check_entry("rst", 16'h0000, 1'b0, 3'd0, 5'd0);
      cyc(4);
      check("scan_col1", 32'(cols_n), 32'h0000_00FD);
      cyc(FRAME - 4);

      // Digit 3 held 10 frames: accept one clock after the 4th frame completes
      keys = hex_key(3);
      frames(4);
      check("lat_before", 32'(entry.user_input), 32'h0);
      cyc(1);
      check("lat_after", 32'(entry.user_input), 32'h3);
      cyc(FRAME - 1);
      frames(5);
      keys = '0;
      frames(10);
      check_entry("hold3", 16'h0003, 1'b1, 3'd1, 5'd3);
      check("hold3_pulses", 32'(pulse_cycles), 32'd0);

      // A..E: fifth digit pushes the oldest out, count saturates at 4
      for (int d = 10; d <= 14; d++) tap(hex_key(d), 5, 5);
      check_entry("hexAE", 16'hBCDE, 1'b1, 3'd4, 5'd26);

      // Clear, then 1,2 and LOAD
      tap(fn_key(FN_CLEAR), 5, 5);
      check_entry("clr1", 16'h0000, 1'b0, 3'd0, 5'd31);
      tap(hex_key(1), 5, 5);
      tap(hex_key(2), 5, 5);
      check_entry("d12", 16'h0012, 1'b1, 3'd2, 5'd2);
      tap(fn_key(FN_LOAD), 5, 5);
      check("load_width", 32'(pulse_cycles), 32'd1);
      check("load_which", 32'(pulse_seen), 32'h0008);
      check("load_ui_at", 32'(ui_at_pulse), 32'h0012);
      check("load_vld_at", 32'(vld_at_pulse), 32'h1);
      check("load_ui_after", 32'(ui_after), 32'h0);
      check("load_vld_after", 32'(vld_after), 32'h0);
      check("load_cnt_after", 32'(cnt_after), 32'h0);
      check_entry("load", 16'h0000, 1'b0, 3'd0, 5'd7);

      // Digit 5 on alternate frames never accumulates 4 in a row
      for (int i = 0; i < 3; i++) tap(hex_key(5), 1, 1);
      frames(4);
      check_entry("bounce5", 16'h0000, 1'b0, 3'd0, 5'd7);

      // Digit 7 held, one empty frame in the middle: still a single accept
      keys = hex_key(7);
      frames(6);
      keys = '0;
      frames(1);
      keys = hex_key(7);
      frames(4);
      keys = '0;
      frames(6);
      check_entry("drop7", 16'h0007, 1'b1, 3'd1, 5'd11);

      // Two keys together are ignored; the survivor then needs 4 frames
      tap(fn_key(FN_CLEAR), 5, 5);
      check_entry("clr2", 16'h0000, 1'b0, 3'd0, 5'd31);
      keys = hex_key(1) | hex_key(2);
      frames(6);
      check("multi_ui", 32'(entry.user_input), 32'h0);
      keys = hex_key(1);
      frames(4);
      check("single_before", 32'(entry.user_input), 32'h0);
      cyc(1);
      check_entry("single1", 16'h0001, 1'b1, 3'd1, 5'd1);
      cyc(FRAME - 1);
      keys = '0;
      frames(5);
      tap(fn_key(FN_CLEAR), 5, 5);
      check_entry("clr3", 16'h0000, 1'b0, 3'd0, 5'd31);
      check("clr3_pulses", 32'(pulse_cycles), 32'd1);

      // Reset while digit 6 is a candidate with count 3
      tap(hex_key(9), 5, 5);
      check_entry("d9", 16'h0009, 1'b1, 3'd1, 5'd17);
      keys = hex_key(6);
      frames(3);
      cyc(2);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      check("mid_rst_cols", 32'(cols_n), 32'h0000_00FE);
      check("mid_rst_pulse", 32'(entry.fn_pulse), 32'h0);
      check_entry("mid_rst", 16'h0000, 1'b0, 3'd0, 5'd0);
      frames(4);
      check("fresh_before", 32'(entry.user_input), 32'h0);
      cyc(1);
      check_entry("fresh6", 16'h0006, 1'b1, 3'd1, 5'd10);
      keys = '0;
      cyc(FRAME - 1);
      frames(5);
      check("end_pulses", 32'(pulse_cycles), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
